// File: rtl/div_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// div_arb_pkg
// Shared types and helpers for the divider arbiter.
//   div_arb_state_e : controller FSM states
//   DIV_WIDTH       : native operand/result width of the shared divider
//   div_special_t   : bypass flag + bypass result
//   div_special()   : detects the RISC-V division corner cases that are
//                     answered without using the divider
// -----------------------------------------------------------------------------
package div_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } div_arb_state_e;

   localparam int DIV_WIDTH = 32;

   typedef struct packed {
      logic                 bypass;
      logic [DIV_WIDTH-1:0] res;
   } div_special_t;

   // Divide-by-zero yields all ones; the signed overflow case (most negative
   // value divided by -1) yields the dividend unchanged.
   function automatic div_special_t div_special(input logic [DIV_WIDTH-1:0] a,
                                                input logic [DIV_WIDTH-1:0] b,
                                                input logic                 is_signed);
      div_special_t r;
      r.bypass = 1'b0;
      r.res    = '0;
      if (b == '0) begin
         r.bypass = 1'b1;
         r.res    = '1;
      end else if (is_signed && (a == {1'b1, {(DIV_WIDTH-1){1'b0}}}) && (b == '1)) begin
         r.bypass = 1'b1;
         r.res    = a;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first requester at or above
// ptr, wrapping around.
//   req     : request vector (N bits)
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant, all zero when nothing requests
//   gnt_idx : binary index of the grant (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int IW = $clog2(N);

   logic found;
   int   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Shares one handshake divider between NUM_REQ requesters, one operation at a
// time. Divide-by-zero and signed overflow are answered directly without
// occupying the divider.
//   clock, nreset        : clock, synchronous active-low reset
//   req_*                : per-requester operation channel (valid/ready)
//   rsp_*                : per-requester result channel (one-hot valid,
//                          shared quotient bus rsp_c_o)
//   div_in_*, div_a/b_o, div_signed_o : divider operand channel
//   div_out_*, div_c_i   : divider result channel
//   dbg_state_o          : current controller state
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. Senders hold valid and payload stable until that edge;
// ready may depend combinationally on valid.
// -----------------------------------------------------------------------------
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = DIV_WIDTH
) (
   input  logic                            clock,
   input  logic                            nreset,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a_i,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b_i,
   input  logic [NUM_REQ-1:0]              req_signed_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   input  logic [NUM_REQ-1:0]              rsp_ready_i,
   output logic [WIDTH-1:0]                rsp_c_o,
   output logic                            div_in_valid_o,
   input  logic                            div_in_ready_i,
   output logic [WIDTH-1:0]                div_a_o,
   output logic [WIDTH-1:0]                div_b_o,
   output logic                            div_signed_o,
   input  logic                            div_out_valid_i,
   output logic                            div_out_ready_o,
   input  logic [WIDTH-1:0]                div_c_i,
   output div_arb_state_e                  dbg_state_o
);

   localparam int IW = $clog2(NUM_REQ);

   div_arb_state_e     state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q, res_q;
   logic               signed_q;
   logic [IW-1:0]      id_q, rr_ptr;

   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;
   logic [WIDTH-1:0]   sel_a, sel_b, sp_res;
   logic               sel_signed, sp_bypass;
   logic               accept, rsp_fire;
   logic [NUM_REQ-1:0] id_oh;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (req_valid_i),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_a      = req_a_i[gnt_idx];
   assign sel_b      = req_b_i[gnt_idx];
   assign sel_signed = req_signed_i[gnt_idx];

   generate
      if (WIDTH == DIV_WIDTH) begin : g_pkg_special
         div_special_t sp;
         assign sp        = div_special(sel_a, sel_b, sel_signed);
         assign sp_bypass = sp.bypass;
         assign sp_res    = sp.res;
      end else begin : g_generic_special
         localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
         assign sp_bypass = (sel_b == '0) ||
                            (sel_signed && (sel_a == MIN_NEG) && (sel_b == '1));
         assign sp_res    = (sel_b == '0) ? '1 : sel_a;
      end
   endgenerate

   // A grant is only offered out of reset so a requester never sees an
   // accept that the reset branch would throw away.
   assign accept   = (state_q == IDLE) && (|req_valid_i) && nreset;
   assign rsp_fire = (state_q == RESP) && rsp_ready_i[id_q];
   assign id_oh    = NUM_REQ'(1) << id_q;

   always_comb begin
      state_d         = state_q;
      req_ready_o     = '0;
      rsp_valid_o     = '0;
      div_in_valid_o  = 1'b0;
      div_out_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o     = nreset ? gnt : '0;
            // Always drain: a result left over from an abandoned op is dropped.
            div_out_ready_o = 1'b1;
            if (accept) state_d = sp_bypass ? RESP : ISSUE;
         end
         ISSUE: begin
            div_in_valid_o = 1'b1;
            if (div_in_ready_i) state_d = WAIT;
         end
         WAIT: begin
            div_out_ready_o = 1'b1;
            if (div_out_valid_i) state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = id_oh;
            if (rsp_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         id_q     <= '0;
         res_q    <= '0;
         rr_ptr   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            signed_q <= sel_signed;
            id_q     <= gnt_idx;
            if (sp_bypass) res_q <= sp_res;
         end
         if ((state_q == WAIT) && div_out_valid_i) res_q <= div_c_i;
         if (rsp_fire) rr_ptr <= (id_q == IW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
      end
   end

   assign rsp_c_o      = res_q;
   assign div_a_o      = a_q;
   assign div_b_o      = b_q;
   assign div_signed_o = signed_q;
   assign dbg_state_o  = state_q;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin controller that shares one handshake divider (`opdiv`) between `NUM_REQ` requesters, e.g. the M-extension execute stage and a secondary unit. It accepts one division at a time and forwards it to the divider. It short-circuits the RISC-V special cases (divide-by-zero, signed overflow) without occupying the divider, and routes the quotient back to the winning requester.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, at least 2.
- `WIDTH`, default 32: operand and result width.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `nreset`  in  1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `req_valid_i`  in  NUM_REQ: per-requester operation valid.
- `req_ready_o`  out  NUM_REQ: per-requester accept; at most one bit high.
- `req_a_i`  in  NUM_REQ×WIDTH: dividends.
- `req_b_i`  in  NUM_REQ×WIDTH: divisors.
- `req_signed_i`  in  NUM_REQ: 1 = signed division, 0 = unsigned.
- `rsp_valid_o`  out  NUM_REQ: one-hot result valid.
- `rsp_ready_i`  in  NUM_REQ: per-requester result accept.
- `rsp_c_o`  out  WIDTH: quotient, shared bus, qualified by `rsp_valid_o`.
- `div_in_valid_o`, `div_in_ready_i`: divider input handshake (out 1 / in 1).
- `div_a_o`, `div_b_o`  out  WIDTH: divider operands.
- `div_signed_o`  out  1: drives the divider's `signal_division` input.
- `div_out_valid_i`  in  1 / `div_out_ready_o`  out  1: divider result handshake.
- `div_c_i`  in  WIDTH: divider quotient.

## Operation
State machine states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Grant = first `i` with `req_valid_i[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready_o[grant]`=1 combinationally; a handshake occurs in the same cycle.
  - On handshake, latch `a`, `b`, `signed` and `id`=grant.
  - If `b`==0, set `res` to all ones and go to RESP.
  - Else if `signed`, `a`==100…0 and `b`==all ones, set `res`=`a` and go to RESP.
  - Otherwise go to ISSUE.
  - `div_out_ready_o`=1 in IDLE so any stale divider result (e.g. after reset) is drained and discarded.
- **ISSUE**
  - `div_in_valid_o`=1 with the latched operands.
  - When `div_in_ready_i`=1, go to WAIT.
- **WAIT**
  - `div_out_ready_o`=1.
  - When `div_out_valid_i`=1, latch `res`=`div_c_i` and go to RESP.
- **RESP**
  - `rsp_valid_o[id]`=1 and `rsp_c_o`=`res`.
  - When `rsp_ready_i[id]`=1, set `rr_ptr`=(`id`+1) mod NUM_REQ and go to IDLE.
- **Requester rule:** once `req_valid_i[i]` is high it must stay high with stable operands until `req_ready_o[i]`. The block does not check this.
- **Other outputs:** outside their states, `div_in_valid_o`, `rsp_valid_o` and `req_ready_o` are 0. `div_a_o`, `div_b_o` and `div_signed_o` always show the latched values.
- **Reset value of every output:** all valids and readies 0 (except `div_out_ready_o`=1, since the FSM resets to IDLE). `rsp_c_o`, `div_a_o` and `div_b_o` are 0. `rr_ptr`=0.
- **Reset mid-operation:** abandons the op with no response issued. Any later divider result is drained in IDLE.

## Timing
- Accept happens at cycle 0 (handshake in IDLE).
- **Normal path:**
  - `div_in_valid_o` rises at cycle 1.
  - WAIT begins the cycle after `div_in_ready_i`.
  - `rsp_valid_o` rises the cycle after `div_out_valid_i`.
  - Controller overhead is 3 cycles plus divider latency.
- **Bypass path:** `rsp_valid_o` rises at cycle 1.
- **Next accept:** the earliest next accept is the cycle after the RESP handshake. There is one op in flight at most.
- **Fairness:**
  - Simultaneous requests are served in round-robin order from `rr_ptr`.
  - A continuously requesting port waits at most NUM_REQ−1 ops.
- **Backpressure:**
  - `rsp_ready_i` low holds RESP indefinitely with `rsp_c_o` stable.
  - `div_in_ready_i` low holds ISSUE with operands stable.

## Structure
- Package `div_arb_pkg`:
  - state enum `div_arb_state_e` {IDLE, ISSUE, WAIT, RESP};
  - `DIV_WIDTH`=32;
  - function `div_special(a, b, signed)` returning the bypass flag and result.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs `req[N]`, `ptr`;
  - outputs one-hot `gnt[N]`, `gnt_idx`;
  - purely combinational.
- Top-level contents: the FSM, the operand/result registers and `rr_ptr`.

## Test plan
- **Single unsigned op:** requester 0, a=100, b=7, unsigned, with a model divider of 5-cycle latency → `rsp_valid_o`=01, `rsp_c_o`=14. The divider sees exactly one input handshake.
- **Divide-by-zero bypass:** requester 1, a=55, b=0 → `rsp_c_o`=FFFFFFFF at cycle 1. `div_in_valid_o` never rises.
- **Signed overflow bypass:** a=80000000, b=FFFFFFFF, signed → `rsp_c_o`=80000000 at cycle 1. Also a=−7, b=2, signed → FFFFFFFD (−3), computed via the divider.
- **Contention:** both requesters valid continuously, 6 ops → grants alternate 0,1,0,1,0,1. Each `rsp_valid_o` goes only to the owner of the op.
- **Backpressure:**
  - hold `rsp_ready_i` low for 10 cycles → `rsp_c_o` stable and no new `req_ready_o`;
  - hold `div_in_ready_i` low for 4 cycles → `div_a_o`/`div_b_o` stable.
- **Reset mid-WAIT:** pulse `nreset` low for one edge while in WAIT → all outputs at their reset values. A later stale `div_out_valid_i` is consumed with no `rsp_valid_o`. Next op a=9, b=3 → 3.
